// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control unit.
//  - Arbitrates per-stage stall requests into a 6-bit hold vector (combinational).
//  - Converts a MEM-stage exception into a registered one-cycle flush plus redirect PC.
//  - Counts cycles in which any stage is held (wrapping 32-bit counter).
//  - Optional stall watchdog, built only when the macro STALL_WDOG_EN is defined:
//    a long run of consecutive stalled cycles forces a flush to WDOG_VECTOR.
// Handshake: none; stall_o is consumed in the same cycle, flush_o/new_pc_o are
// valid together for exactly one cycle after the triggering event.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [15:0] WDOG_LIMIT  = 16'd1024,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt_o,
  output logic        wdog_o
);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  logic        state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cnt_q;
  logic [5:0]  req_vec;
  logic        exc_hit;
  logic        stall_active;
  logic        wdog_trip;

  // A real exception is only acted on in RUN; in FLUSH the MEM stage holds a
  // stale younger instruction that the flush is already clearing.
  assign exc_hit = (state_q == ST_RUN) && (excepttype_i != 32'd0);

  // Stall arbitration: the deepest requesting stage holds itself and everything older.
  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem_i)     req_vec = 6'b011111;
    else if (stallreq_ex_i) req_vec = 6'b001111;
    else if (stallreq_id_i) req_vec = 6'b000111;
    else if (stallreq_if_i) req_vec = 6'b000011;
  end

  // Holding stages is pointless while the pipe is being (or about to be) flushed.
  assign stall_o      = (rst || (state_q == ST_FLUSH) || exc_hit) ? 6'b000000 : req_vec;
  assign stall_active = (stall_o != 6'b000000);

  // Next-state logic: RUN enters FLUSH on an exception (priority) or watchdog trip.
  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    if (state_q == ST_RUN) begin
      if (exc_hit) begin
        state_d  = ST_FLUSH;
        flush_d  = 1'b1;
        new_pc_d = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end else if (wdog_trip) begin
        state_d  = ST_FLUSH;
        flush_d  = 1'b1;
        new_pc_d = WDOG_VECTOR;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  // FSM and flush/redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Stall-cycle performance counter; survives flushes, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 32'd0;
    else if (stall_active) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

`ifdef STALL_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_q;

  // Trip on the stalled cycle that brings the consecutive count up to the limit.
  assign wdog_trip = (state_q == ST_RUN) && (excepttype_i == 32'd0) && stall_active &&
                     (wdog_cnt_q == (WDOG_LIMIT - 16'd1));

  // Consecutive-stall count: cleared by any unstalled cycle and by entry to FLUSH.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q + 16'd1;
    if (!stall_active || exc_hit || wdog_trip) wdog_cnt_d = 16'd0;
  end

  // Watchdog count and one-cycle trip pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= 16'd0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_trip;
    end
  end

  assign wdog_o = wdog_q;
`else
  logic [15:0] wdog_cfg_unused;

  assign wdog_cfg_unused = WDOG_LIMIT;
  assign wdog_trip       = 1'b0;
  assign wdog_o          = 1'b0;
`endif

  assign flush_o     = flush_q;
  assign new_pc_o    = new_pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl.
// Each vector drives inputs just after a posedge and queues the outputs expected
// during that cycle; a monitor on the negedge pops and compares them.
// The watchdog vectors are only applied when STALL_WDOG_EN is defined.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] stall_cnt_o;
  logic        wdog_o;

  // {stall[5:0], flush, new_pc[31:0], stall_cnt[31:0], wdog}
  logic [71:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_LIMIT (16'd4),
    .WDOG_VECTOR(32'h0000_0040)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if_i (stallreq_if_i),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .stall_cnt_o   (stall_cnt_o),
    .wdog_o        (wdog_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector now and queue its expected outputs.
  task automatic apply(input logic r, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic [31:0] e_cnt, input logic e_wdog);
    rst            = r;
    stallreq_mem_i = req[3];
    stallreq_ex_i  = req[2];
    stallreq_id_i  = req[1];
    stallreq_if_i  = req[0];
    excepttype_i   = exc;
    cp0_epc_i      = epc;
    exp_q.push_back({e_stall, e_flush, e_pc, e_cnt, e_wdog});
  endtask

  // Wait for the next cycle, then drive a vector.
  task automatic vec(input logic r, input logic [3:0] req, input logic [31:0] exc,
                     input logic [31:0] epc, input logic [5:0] e_stall, input logic e_flush,
                     input logic [31:0] e_pc, input logic [31:0] e_cnt, input logic e_wdog);
    @(posedge clk);
    #1;
    apply(r, req, exc, epc, e_stall, e_flush, e_pc, e_cnt, e_wdog);
  endtask

  // Scoreboard monitor: compare the oldest expectation against the outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [71:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (stall_o !== e[71:66]) begin
        n_fail++;
        $display("FAIL vec%0d stall_o: got %b, expected %b", n_vec, stall_o, e[71:66]);
      end
      if (flush_o !== e[65]) begin
        n_fail++;
        $display("FAIL vec%0d flush_o: got %b, expected %b", n_vec, flush_o, e[65]);
      end
      if (new_pc_o !== e[64:33]) begin
        n_fail++;
        $display("FAIL vec%0d new_pc_o: got %h, expected %h", n_vec, new_pc_o, e[64:33]);
      end
      if (stall_cnt_o !== e[32:1]) begin
        n_fail++;
        $display("FAIL vec%0d stall_cnt_o: got %h, expected %h", n_vec, stall_cnt_o, e[32:1]);
      end
      if (wdog_o !== e[0]) begin
        n_fail++;
        $display("FAIL vec%0d wdog_o: got %b, expected %b", n_vec, wdog_o, e[0]);
      end
    end
  end

  // Directed stimulus
  initial begin
    rst            = 1'b1;
    stallreq_mem_i = 1'b1;
    stallreq_ex_i  = 1'b1;
    stallreq_id_i  = 1'b1;
    stallreq_if_i  = 1'b1;
    excepttype_i   = 32'h1;
    cp0_epc_i      = 32'h5;
    repeat (2) @(posedge clk);

    //  rst  {m,e,i,f} exc      epc        stall     fl  new_pc   cnt      wdog
    vec(1'b1, 4'b1111, 32'h1,   32'h5,     6'h00, 1'b0, 32'h0,   32'd0, 1'b0); // reset dominates
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h0,   32'd0, 1'b0);
    vec(1'b0, 4'b0010, 32'h0,   32'h0,     6'h07, 1'b0, 32'h0,   32'd0, 1'b0); // id
    vec(1'b0, 4'b1010, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h0,   32'd1, 1'b0); // mem beats id
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h0,   32'd2, 1'b0);
    vec(1'b0, 4'b0001, 32'h0,   32'h0,     6'h03, 1'b0, 32'h0,   32'd2, 1'b0); // if
    vec(1'b0, 4'b0100, 32'h0,   32'h0,     6'h0F, 1'b0, 32'h0,   32'd3, 1'b0); // ex
    vec(1'b0, 4'b0100, 32'h1,   32'h0,     6'h00, 1'b0, 32'h0,   32'd4, 1'b0); // exception kills stall
    vec(1'b0, 4'b0100, 32'h0,   32'h0,     6'h00, 1'b1, 32'h20,  32'd4, 1'b0); // flush, EXC_VECTOR
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h20,  32'd4, 1'b0); // pc holds
    vec(1'b0, 4'b0000, 32'he,   32'h1234,  6'h00, 1'b0, 32'h20,  32'd4, 1'b0); // ERET
    vec(1'b0, 4'b1000, 32'h3,   32'h0,     6'h00, 1'b1, 32'h1234,32'd4, 1'b0); // ignored in FLUSH
    vec(1'b0, 4'b0000, 32'h3,   32'h0,     6'h00, 1'b0, 32'h1234,32'd4, 1'b0); // back-to-back
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b1, 32'h20,  32'd4, 1'b0);
    vec(1'b0, 4'b0000, 32'h1,   32'h0,     6'h00, 1'b0, 32'h20,  32'd4, 1'b0);
    vec(1'b1, 4'b1000, 32'h0,   32'h0,     6'h00, 1'b1, 32'h20,  32'd4, 1'b0); // reset in FLUSH
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h0,   32'd0, 1'b0);

    // Counter wrap: preload all-ones, then one stalled cycle.
    @(posedge clk);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    apply(1'b0, 4'b1000, 32'h0, 32'h0,      6'h1F, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0);
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h0,   32'd0, 1'b0);

`ifdef STALL_WDOG_EN
    // Four consecutive stalled cycles trip the watchdog (limit 4).
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h0,   32'd0, 1'b0);
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h0,   32'd1, 1'b0);
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h0,   32'd2, 1'b0);
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h0,   32'd3, 1'b0);
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b1, 32'h40,  32'd4, 1'b1);
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b0, 32'h40,  32'd4, 1'b0);
    // Exception in the would-be trip cycle wins.
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h40,  32'd4, 1'b0);
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h40,  32'd5, 1'b0);
    vec(1'b0, 4'b1000, 32'h0,   32'h0,     6'h1F, 1'b0, 32'h40,  32'd6, 1'b0);
    vec(1'b0, 4'b1000, 32'h1,   32'h0,     6'h00, 1'b0, 32'h40,  32'd7, 1'b0);
    vec(1'b0, 4'b0000, 32'h0,   32'h0,     6'h00, 1'b1, 32'h20,  32'd7, 1'b0);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
